// File: rtl/q_seq_ctrl.sv
// q_seq_ctrl: Q-table sequencer with valid/ready output, programmable dwell and loop playback.
// Define Q_SEQ_PASS_CNT_EN to add the saturating pass_cnt output.
module q_seq_ctrl #(
    parameter int Q_W     = 16,
    parameter int DEPTH   = 64,
    parameter int AW      = $clog2(DEPTH),
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [Q_W-1:0]     cfg_wdata,
    input  logic [AW:0]        cfg_len,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               start,
    input  logic               abort,
    output logic [Q_W-1:0]     q_data,
    output logic               q_valid,
    input  logic               q_ready,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      idx
`ifdef Q_SEQ_PASS_CNT_EN
    ,
    output logic [15:0]        pass_cnt
`endif
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] PRESENT = 3'd2;
    localparam logic [2:0] DWELL   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    logic [2:0]         state;
    logic [2:0]         adv_state;
    logic [AW:0]        len_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] cnt;
    logic               loop_r;
    logic               last;
    logic               adv;
    logic [AW-1:0]      adv_idx;
    logic [Q_W-1:0]     mem [DEPTH];
    // adv is the single "move past the current entry" event, shared with pass_cnt
    always_comb begin
        last      = {1'b0, idx} == len_r - (AW+1)'(1);
        adv       = !abort && ((state == PRESENT && q_ready && dwell_r == '0) ||
                               (state == DWELL && cnt == DWELL_W'(1)));
        adv_state = (last && !loop_r) ? DONE : FETCH;
        adv_idx   = last ? '0 : idx + AW'(1);
    end
    assign q_valid = state == PRESENT;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE)
            mem[cfg_addr] <= cfg_wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            len_r   <= '0;
            dwell_r <= '0;
            cnt     <= '0;
            loop_r  <= 1'b0;
            q_data  <= '0;
        end else if (abort) begin
            state <= IDLE;
            idx   <= '0;
        end else if (adv) begin
            state <= adv_state;
            idx   <= adv_idx;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len_r   <= (cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_len;
                    dwell_r <= cfg_dwell;
                    loop_r  <= cfg_loop;
                    idx     <= '0;
                    state   <= (cfg_len == '0) ? DONE : FETCH;
                end
                FETCH: begin
                    q_data <= mem[idx];
                    state  <= PRESENT;
                end
                PRESENT: if (q_ready) begin
                    cnt   <= dwell_r;
                    state <= DWELL;
                end
                DWELL:   cnt <= cnt - DWELL_W'(1);
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef Q_SEQ_PASS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pass_cnt <= '0;
        else if (state == IDLE && start && !abort)
            pass_cnt <= '0;
        else if (adv && last && pass_cnt != 16'hFFFF)
            pass_cnt <= pass_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_q_seq_ctrl.sv
// tb_q_seq_ctrl: vector table, corner sequences and randomized runs against a playback model.
module tb_q_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic [6:0]  cfg_len = '0;
    logic [15:0] cfg_dwell = '0;
    logic        cfg_loop = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] q_data;
    logic        q_valid;
    logic        q_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [5:0]  idx;
`ifdef Q_SEQ_PASS_CNT_EN
    logic [15:0] pass_cnt;
`endif
    logic [15:0] ref_tbl [64];
    int n_chk = 0;
    int n_pass = 0;
    int dc, rs;
    logic [15:0] fq;

    typedef struct {
        int          len;
        int          dwell;
        int          exp_cyc;
        int          exp_rises;
        logic [15:0] exp_first;
    } vec_t;
    vec_t vt [8];

    q_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_len(cfg_len), .cfg_dwell(cfg_dwell),
        .cfg_loop(cfg_loop), .start(start), .abort(abort), .q_data(q_data),
        .q_valid(q_valid), .q_ready(q_ready), .busy(busy), .done(done),
`ifdef Q_SEQ_PASS_CNT_EN
        .pass_cnt(pass_cnt),
`endif
        .idx(idx)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_addr = a[5:0];
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        ref_tbl[a] = d;
    endtask

    // One playback from IDLE; the model is: the k-th accepted value is tbl[k mod L],
    // rises are 2 cycles after start or dwell+2 after a handshake, done dwell+1 after the last.
    task automatic play(input int len, input int dwell, input int loop, input int pct,
                        input int stall, input int max_hs, input int dly,
                        output int done_cyc, output int rises, output logic [15:0] first_q);
        int L, cyc, k, last_ev, vcnt;
        bit pv, fin;
        L = len > 64 ? 64 : len;
        cfg_len = len[6:0];
        cfg_dwell = dwell[15:0];
        cfg_loop = loop != 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; k = 0; last_ev = 0; vcnt = 0; pv = 0; fin = 0;
        done_cyc = -1; rises = 0; first_q = '0;
        chk("busy_rise", busy, 1);
        while (!fin && cyc < 4000) begin
            q_ready = (k == 0 && vcnt < stall) ? 1'b0 : ($urandom_range(99) < pct);
            if (L == 0) chk("valid_len0", q_valid, 0);
            if (q_valid && L != 0) begin
                if (!pv) begin
                    rises++;
                    chk("rise_gap", cyc - last_ev, k == 0 ? 2 : dwell + 2);
                    if (rises == 1) first_q = q_data;
                end
                chk("q_data", q_data, ref_tbl[k % L]);
                chk("idx", idx, k % L);
                if (k == 0) vcnt++;
                if (q_ready) begin
                    k++;
                    last_ev = cyc;
                end
            end
            pv = q_valid;
            if (done) begin
                if (loop != 0 && L != 0) chk("no_done_loop", done, 0);
                else begin
                    chk("done_gap", cyc - last_ev, L == 0 ? 1 : dwell + 1);
                    chk("done_cnt", k, L);
                end
                done_cyc = cyc;
                tick();
                chk("done_width", done, 0);
                chk("busy_fall", busy, 0);
                fin = 1;
            end else if (loop != 0 && L != 0 && k == max_hs) begin
                for (int j = 0; j < dly; j++) begin
                    tick();
                    q_ready = 1'b0;
                end
                abort = 1'b1;
                tick();
                abort = 1'b0;
                q_ready = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_valid", q_valid, 0);
                chk("abort_done", done, 0);
                chk("abort_idx", idx, 0);
                fin = 1;
            end else begin
                tick();
                cyc++;
            end
        end
        q_ready = 1'b0;
        if (!fin) begin
            n_chk++;
            $display("FAIL timeout: no done/abort after %0d cycles (len %0d)", cyc, len);
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
    endtask

    initial begin
        vt[0] = '{4, 0, 9, 4, 16'd10};
        vt[1] = '{2, 5, 15, 2, 16'd10};
        vt[2] = '{0, 3, 1, 0, 16'd0};
        vt[3] = '{1, 0, 3, 1, 16'd10};
        vt[4] = '{3, 1, 10, 3, 16'd10};
        vt[5] = '{70, 0, 129, 64, 16'd10};
        vt[6] = '{64, 2, 257, 64, 16'd10};
        vt[7] = '{127, 0, 129, 64, 16'd10};

        tick();
        tick();
        chk("rst_q_data", q_data, 0);
        chk("rst_valid", q_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", idx, 0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) wr(i, i < 4 ? 16'(10 * (i + 1)) : 16'(16'h1000 + i));

        foreach (vt[i]) begin
            play(vt[i].len, vt[i].dwell, 0, 100, 0, 0, 0, dc, rs, fq);
            chk("vec_done_cyc", dc, vt[i].exp_cyc);
            chk("vec_rises", rs, vt[i].exp_rises);
            if (vt[i].exp_rises != 0) chk("vec_first", fq, vt[i].exp_first);
        end

        play(2, 5, 0, 100, 3, 0, 0, dc, rs, fq);
        play(3, 2, 1, 100, 0, 7, 1, dc, rs, fq);
        play(3, 0, 1, 100, 0, 5, 0, dc, rs, fq);

        fork
            play(4, 1, 0, 100, 0, 0, 0, dc, rs, fq);
            begin
                repeat (4) tick();
                cfg_we = 1'b1;
                cfg_addr = 6'd1;
                cfg_wdata = 16'hDEAD;
                tick();
                cfg_we = 1'b0;
            end
        join
        play(4, 0, 0, 100, 0, 0, 0, dc, rs, fq);

        cfg_len = 7'd4;
        cfg_dwell = '0;
        cfg_loop = 1'b0;
        q_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_rst_q_data", q_data, 30);
        chk("pre_rst_idx", idx, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_q_data", q_data, 0);
        chk("mid_rst_valid", q_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_idx", idx, 0);
        q_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        play(4, 0, 0, 100, 0, 0, 0, dc, rs, fq);
        chk("rerun_cyc", dc, 9);

`ifdef Q_SEQ_PASS_CNT_EN
        play(2, 0, 1, 100, 0, 10, 1, dc, rs, fq);
        chk("pass_cnt_5", pass_cnt, 5);
        play(0, 0, 0, 100, 0, 0, 0, dc, rs, fq);
        chk("pass_cnt_clr", pass_cnt, 0);
`endif

        for (int r = 0; r < 25; r++) begin
            wr($urandom_range(63), 16'($urandom));
            wr($urandom_range(63), 16'($urandom));
            play(r == 12 ? 100 : $urandom_range(12), $urandom_range(4), $urandom_range(1),
                 $urandom_range(100, 30), $urandom_range(2), $urandom_range(20, 1),
                 $urandom_range(2), dc, rs, fq);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
